aluv_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 10-lane vector ALU (ALUV). It accepts whole-vector operations from two requesters, such as the core's vector issue stage and the image-filter engine. Each accepted operation's control code and operands are registered and held on the ALUV inputs for one execute cycle. The 10 lane results and NZCV flags are captured and returned on a shared response channel tagged with the requester ID. Arbitration is round-robin, and one operation is in flight at a time.

---
 rtl/aluv_arbiter.sv | 143 ++++++++++++++
 tb/tb_aluv_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aluv_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the 10-lane ALUV, one operation in flight.
// Optional per-lane masking is enabled by defining ALUV_ARB_MASK_EN.
module aluv_arbiter #(
    parameter int unsigned BITS  = 32,
    parameter int unsigned LANES = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0][3:0]                     req_ctrl,
    input  logic [1:0][LANES-1:0][BITS-1:0]     req_a,
    input  logic [1:0][LANES-1:0][BITS-1:0]     req_b,
`ifdef ALUV_ARB_MASK_EN
    input  logic [1:0][LANES-1:0]               req_mask,
`endif
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_id,
    output logic [LANES-1:0][BITS-1:0]          rsp_result,
    output logic [LANES-1:0][3:0]               rsp_nzcv,
    output logic [3:0]                          aluv_ctrl,
    output logic [LANES-1:0][BITS-1:0]          aluv_a,
    output logic [LANES-1:0][BITS-1:0]          aluv_b,
    input  logic [LANES-1:0][BITS-1:0]          aluv_result,
    input  logic [LANES-1:0][3:0]               aluv_nzcv,
    output logic                                busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e                     state_q, state_d;
    logic                       last_id_q, cur_id_q;
    logic [3:0]                 ctrl_q;
    logic [LANES-1:0][BITS-1:0] a_q, b_q, res_q, res_d;
    logic [LANES-1:0][3:0]      nzcv_q, nzcv_d;
    logic [LANES-1:0]           lane_en;
    logic                       grant, accept;

`ifdef ALUV_ARB_MASK_EN
    logic [LANES-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= req_mask[grant];
        end
    end

    assign lane_en = mask_q;
`else
    assign lane_en = '1;
`endif

    // Contention goes to the requester not served last; a lone requester always wins.
    always_comb begin
        if (req_valid[0] && req_valid[1]) begin
            grant = ~last_id_q;
        end else begin
            grant = req_valid[1];
        end
        accept    = (state_q == StIdle) && req_valid[grant] && rst_n;
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        res_d  = '0;
        nzcv_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                res_d[i]  = aluv_result[i];
                nzcv_d[i] = aluv_nzcv[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q <= 1'b1;
            cur_id_q  <= 1'b0;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            nzcv_q    <= '0;
        end else begin
            if (accept) begin
                ctrl_q   <= req_ctrl[grant];
                a_q      <= req_a[grant];
                b_q      <= req_b[grant];
                cur_id_q <= grant;
            end
            if (state_q == StExec) begin
                res_q  <= res_d;
                nzcv_q <= nzcv_d;
            end
            if (state_q == StResp && rsp_ready) begin
                last_id_q <= cur_id_q;
            end
        end
    end

    always_comb begin
        aluv_ctrl = ctrl_q;
        aluv_a    = '0;
        aluv_b    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                aluv_a[i] = a_q[i];
                aluv_b[i] = b_q[i];
            end
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = cur_id_q;
    assign rsp_result = res_q;
    assign rsp_nzcv   = nzcv_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_aluv_arbiter.sv
// Scoreboard bench for aluv_arbiter with a behavioural ALUV stand-in on the execute port.
// Define ALUV_ARB_MASK_EN to also exercise lane masking.
module tb_aluv_arbiter;

    localparam int unsigned BITS  = 32;
    localparam int unsigned LANES = 10;

    typedef logic [LANES-1:0][BITS-1:0] vec_t;
    typedef logic [LANES-1:0][3:0]      flg_t;
    typedef struct {
        logic [3:0]       ctrl;
        vec_t             a;
        vec_t             b;
        logic [LANES-1:0] mask;
    } op_t;
    typedef struct {
        logic id;
        vec_t res;
        flg_t nzcv;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic [1:0]                      req_valid;
    logic [1:0]                      req_ready;
    logic [1:0][3:0]                 req_ctrl;
    logic [1:0][LANES-1:0][BITS-1:0] req_a, req_b;
`ifdef ALUV_ARB_MASK_EN
    logic [1:0][LANES-1:0]           req_mask;
`endif
    logic                            rsp_valid, rsp_ready, rsp_id, busy;
    vec_t                            rsp_result, aluv_a, aluv_b, aluv_result;
    flg_t                            rsp_nzcv, aluv_nzcv;
    logic [3:0]                      aluv_ctrl;

    op_t  q0[$], q1[$];
    exp_t sb[$];
    logic acc[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [1:0] s_ready;
    logic s_rsp_valid, s_busy;
    logic [1:0] pend;

    always #5 clk = ~clk;

    aluv_arbiter #(.BITS(BITS), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ctrl    (req_ctrl),
        .req_a       (req_a),
        .req_b       (req_b),
`ifdef ALUV_ARB_MASK_EN
        .req_mask    (req_mask),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_nzcv    (rsp_nzcv),
        .aluv_ctrl   (aluv_ctrl),
        .aluv_a      (aluv_a),
        .aluv_b      (aluv_b),
        .aluv_result (aluv_result),
        .aluv_nzcv   (aluv_nzcv),
        .busy        (busy)
    );

    // Returns {nzcv, result} for one lane.
    function automatic logic [BITS+3:0] aluv_lane(input logic [3:0] c, input logic [BITS-1:0] a,
                                                  input logic [BITS-1:0] b);
        logic [BITS:0]   w;
        logic [BITS-1:0] r;
        logic            cf, vf;
        w  = '0;
        cf = 1'b0;
        vf = 1'b0;
        case (c)
            4'h0: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[BITS-1:0];
                cf = w[BITS];
                vf = (a[BITS-1] == b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
            end
            4'h1: begin
                w  = {1'b0, a} - {1'b0, b};
                r  = w[BITS-1:0];
                cf = ~w[BITS];
                vf = (a[BITS-1] != b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
            end
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            4'h5:    r = a << b[4:0];
            default: r = a;
        endcase
        return {r[BITS-1], (r == '0), cf, vf, r};
    endfunction

    always_comb begin
        aluv_result = '0;
        aluv_nzcv   = '0;
        for (int i = 0; i < LANES; i++) begin
            {aluv_nzcv[i], aluv_result[i]} = aluv_lane(aluv_ctrl, aluv_a[i], aluv_b[i]);
        end
    end

    function automatic exp_t make_exp(input logic id, input op_t op);
        exp_t             e;
        logic [BITS+3:0]  t;
        e.id = id;
        for (int i = 0; i < LANES; i++) begin
            t = aluv_lane(op.ctrl, op.a[i], op.b[i]);
            e.res[i]  = op.mask[i] ? t[BITS-1:0] : '0;
            e.nzcv[i] = op.mask[i] ? t[BITS+3:BITS] : 4'h0;
        end
        return e;
    endfunction

    function automatic op_t mk_op(input logic [3:0] c);
        op_t op;
        op.ctrl = c;
        op.mask = '1;
        for (int i = 0; i < LANES; i++) begin
            op.a[i] = $urandom;
            op.b[i] = $urandom;
        end
        return op;
    endfunction

    task automatic check(input string tag, input logic [LANES*BITS-1:0] got,
                         input logic [LANES*BITS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic id, input op_t op, input bit want_rsp);
        if (id) q1.push_back(op);
        else    q0.push_back(op);
        if (want_rsp) sb.push_back(make_exp(id, op));
    endtask

    task automatic drive_req(input int r, input op_t op, input bit v);
        req_valid[r] = v;
        req_ctrl[r]  = v ? op.ctrl : 4'h0;
        req_a[r]     = v ? op.a : '0;
        req_b[r]     = v ? op.b : '0;
`ifdef ALUV_ARB_MASK_EN
        req_mask[r]  = v ? op.mask : '0;
`endif
    endtask

    // One clock: drive heads of the requester queues, sample at negedge, score responses.
    task automatic tick();
        op_t  nul;
        exp_t e;
        nul = mk_op(4'h0);
        drive_req(0, (q0.size() != 0) ? q0[0] : nul, q0.size() != 0);
        drive_req(1, (q1.size() != 0) ? q1[0] : nul, q1.size() != 0);
        @(negedge clk);
        s_ready     = req_ready;
        s_rsp_valid = rsp_valid;
        s_busy      = busy;
        if (req_ready == 2'b11) check("ready_onehot", req_ready, 2'b01);
        if (req_ready[0] && req_valid[0]) begin void'(q0.pop_front()); acc.push_back(1'b0); end
        if (req_ready[1] && req_valid[1]) begin void'(q1.pop_front()); acc.push_back(1'b1); end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", rsp_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_result", rsp_result, e.res);
                check("rsp_nzcv", rsp_nzcv, e.nzcv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, sb.size() + q0.size() + q1.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requesters must hold valid until accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= req_valid & ~req_ready;
    end
    always @(negedge clk) begin
        if (rst_n && |(pend & ~req_valid)) $error("request valid dropped before ready");
    end

    initial begin
        op_t o;
        rst_n     = 1'b0;
        req_valid = '0;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
`ifdef ALUV_ARB_MASK_EN
        req_mask  = '0;
`endif
        rsp_ready = 1'b1;
        #3;
        check("rst_ctl", {rsp_valid, rsp_id, busy, req_ready, aluv_ctrl}, '0);
        check("rst_a", aluv_a, '0);
        check("rst_b", aluv_b, '0);
        check("rst_res", rsp_result, '0);
        check("rst_nzcv", rsp_nzcv, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic add with A[i]=i, B[i]=10, checking grant and two-edge latency.
        o = mk_op(4'h0);
        for (int i = 0; i < LANES; i++) begin
            o.a[i] = i;
            o.b[i] = 10;
        end
        push(1'b0, o, 1'b1);
        tick();
        check("t1_ready", s_ready, 2'b01);
        tick();
        check("t1_exec", {s_rsp_valid, s_busy}, 2'b01);
        tick();
        check("t1_rsp", s_rsp_valid, 1'b1);
        tick();
        check("t1_idle", s_busy, 1'b0);

        // Contention after reset alternates 0,1,0,1.
        do_reset();
        acc.delete();
        for (int k = 0; k < 4; k++) push(k[0], mk_op(4'(k + 1)), 1'b1);
        drain("t2_drain", 40);
        check("t2_nacc", acc.size(), 4);
        if (acc.size() == 4) check("t2_order", {acc[0], acc[1], acc[2], acc[3]}, 4'b0101);

        // Back-pressure: RESP holds while rsp_ready is low, nothing else accepted.
        rsp_ready = 1'b0;
        push(1'b0, mk_op(4'h1), 1'b1);
        push(1'b1, mk_op(4'h5), 1'b1);
        tick();
        check("t3_grant", s_ready, 2'b01);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall", {s_rsp_valid, s_busy, s_ready}, 4'b1100);
            check("t3_hold", rsp_result, sb[0].res);
            check("t3_hold_nzcv", rsp_nzcv, sb[0].nzcv);
            check("t3_hold_id", rsp_id, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        tick();
        check("t3_next", {s_busy, s_ready}, 3'b010);
        drain("t3_drain", 20);

        // Lone requester 1 right after it was served last.
        push(1'b1, mk_op(4'h4), 1'b1);
        tick();
        check("t4_grant", s_ready, 2'b10);
        drain("t4_drain", 10);

        // Reset during EXEC drops the transaction.
        o = mk_op(4'h3);
        push(1'b0, o, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_ctl", {rsp_valid, busy, req_ready, aluv_ctrl, rsp_id}, '0);
        check("t5_a", aluv_a, '0);
        check("t5_res", rsp_result, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_norsp", {s_rsp_valid, s_busy}, 2'b00);
        end

`ifdef ALUV_ARB_MASK_EN
        // Only lanes 0 and 2 active; subtract so masked lanes would otherwise flag Z.
        o = mk_op(4'h1);
        o.mask = 10'b0000000101;
        push(1'b0, o, 1'b1);
        drain("t6_drain", 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
